nibble_serial_adder: RTL

//  - Multi-cycle wide adder/subtractor that drives a 4-bit adder datapath one nibble per clock, LSB nibble first.
//  - Ripples the carry between cycles through a register.
//  - Sits between the operand source (register file / decoder) and the result writeback.
//  - valid/ready handshake on both sides; returns result plus C/V/Z flags.

---
 rtl/alu_pkg.sv | 13 +
 rtl/nibble_serial_adder_if.sv | 48 ++++
 rtl/nibble_add4.sv | 19 +
 rtl/nibble_serial_adder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor:
// datapath slice width and FSM state encoding.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result bus of the nibble-serial adder.
// Optional macro ALU_CARRY_IN_EN adds the cin request field.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. A valid
// side never depends combinationally on the matching ready, and the producer
// of out_valid holds result and flags stable until that transfer edge.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
`ifdef ALU_CARRY_IN_EN
  logic         cin;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

`ifdef ALU_CARRY_IN_EN
  modport master (
    output in_valid, op_a, op_b, sub, cin, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );
  modport slave (
    input  in_valid, op_a, op_b, sub, cin, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );
`else
  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );
  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );
`endif

endinterface

// File: rtl/nibble_add4.sv
// Combinational 4-bit adder slice: {cout, sum} = a + b + cin.
module nibble_add4
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] full;

  // One extra bit captures the carry out of the slice.
  assign full = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
  assign sum  = full[NIBBLE_W-1:0];
  assign cout = full[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder/subtractor built from a single 4-bit slice,
// processing one nibble per clock, least significant nibble first.
// Optional macro ALU_CARRY_IN_EN: initial carry comes from bus.cin
// (SBC-style subtract) instead of being forced to the sub bit.
module nibble_serial_adder
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus,
  output state_t                dbgState
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state;
  state_t              nextState;
  logic [IDX_W-1:0]    idx;
  logic [W-1:0]        aReg;
  logic [W-1:0]        bEffReg;
  logic [W-1:0]        resultReg;
  logic [W-1:0]        resultNext;
  logic                carryReg;
  logic                carryOutReg;
  logic                overflowReg;
  logic                zeroReg;
  logic [NIBBLE_W-1:0] aNib;
  logic [NIBBLE_W-1:0] bNib;
  logic [NIBBLE_W-1:0] sumNib;
  logic                coutNib;
  logic                accept;
  logic                lastStep;
  logic                initCarry;
  logic [W-1:0]        bEffIn;

  // Requests are only taken in IDLE, so accept does not need in_ready fed back.
  assign accept   = bus.in_valid && (state == IDLE);
  assign lastStep = (state == RUN) && (idx == LAST_IDX);
  assign bEffIn   = bus.sub ? ~bus.op_b : bus.op_b;

`ifdef ALU_CARRY_IN_EN
  assign initCarry = bus.cin;
`else
  assign initCarry = bus.sub;
`endif

  // Select the current nibble of each latched operand.
  assign aNib = aReg[NIBBLE_W*idx +: NIBBLE_W];
  assign bNib = bEffReg[NIBBLE_W*idx +: NIBBLE_W];

  nibble_add4 u_add (
    .a    (aNib),
    .b    (bNib),
    .cin  (carryReg),
    .sum  (sumNib),
    .cout (coutNib)
  );

  // Result with the current slice merged in; feeds both the register and the flags.
  always_comb begin
    resultNext = resultReg;
    resultNext[NIBBLE_W*idx +: NIBBLE_W] = sumNib;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    nextState     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) nextState = RUN;
      end
      RUN: begin
        if (idx == LAST_IDX) nextState = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Operand latch, per-nibble accumulation, carry ripple and final flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      aReg        <= '0;
      bEffReg     <= '0;
      resultReg   <= '0;
      carryReg    <= 1'b0;
      carryOutReg <= 1'b0;
      overflowReg <= 1'b0;
      zeroReg     <= 1'b0;
    end else if (accept) begin
      idx         <= '0;
      aReg        <= bus.op_a;
      bEffReg     <= bEffIn;
      resultReg   <= '0;
      carryReg    <= initCarry;
      carryOutReg <= 1'b0;
      overflowReg <= 1'b0;
      zeroReg     <= 1'b0;
    end else if (state == RUN) begin
      resultReg <= resultNext;
      carryReg  <= coutNib;
      idx       <= lastStep ? '0 : idx + 1'b1;
      if (lastStep) begin
        carryOutReg <= coutNib;
        overflowReg <= (aReg[W-1] == bEffReg[W-1]) && (resultNext[W-1] != aReg[W-1]);
        zeroReg     <= ~|resultNext;
      end
    end
  end

  assign bus.result    = resultReg;
  assign bus.carry_out = carryOutReg;
  assign bus.overflow  = overflowReg;
  assign bus.zero      = zeroReg;
  assign dbgState      = state;

endmodule
